// File: rtl/eeprom_pkg.sv
// Shared widths and address helpers for the cartridge save-image dual-port RAM.
package eeprom_pkg;

    localparam int ADDR_A_W = 16;
    localparam int ADDR_B_W = 13;
    localparam int DATA_B_W = 8;
    localparam int LANES    = 8;
    localparam int SEL_W    = 3;
    localparam int ROW_W    = ADDR_B_W;

    // A port-A bit address splits into a byte row and a bit lane.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [SEL_W-1:0] sel;
    } bit_addr_t;

    function automatic logic lane_hit(input logic [SEL_W-1:0] sel, input logic [SEL_W-1:0] lane);
        return sel == lane;
    endfunction

endpackage

// File: rtl/eeprom_bit_lane.sv
// One bit-slice of the save image: a 1-bit wide dual-port RAM with registered reads on both ports.
module eeprom_bit_lane
    import eeprom_pkg::*;
#(
    parameter int ROWS = 8192
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_we,
    input  logic             a_re,
    input  logic [ROW_W-1:0] a_row,
    input  logic             a_din,
    output logic             a_q,
    input  logic             b_we,
    input  logic             b_re,
    input  logic [ROW_W-1:0] b_row,
    input  logic             b_din,
    output logic             b_q
);

    logic mem [ROWS];
    logic a_q_reg;
    logic b_q_reg;

    // Same-row collisions are resolved before reaching the lane, so the write order here is irrelevant.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_row] <= b_din;
        end
        if (a_we) begin
            mem[a_row] <= a_din;
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q_reg <= 1'b0;
            b_q_reg <= 1'b0;
        end else begin
            if (a_re) begin
                a_q_reg <= mem[a_row];
            end
            if (b_re) begin
                b_q_reg <= mem[b_row];
            end
        end
    end

    assign a_q = a_q_reg;
    assign b_q = b_q_reg;

endmodule

// File: rtl/eeprom_dpram.sv
// Save-image RAM: bit-wide port A for the serial EEPROM engine, byte-wide port B for the soft core.
module eeprom_dpram
    import eeprom_pkg::*;
#(
    parameter int DEPTH_BITS = 65536
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cea,
    input  logic [ADDR_A_W-1:0] ada,
    input  logic                wrea,
    input  logic                ocea,
    input  logic                dina,
    output logic                douta,
    input  logic                ceb,
    input  logic [ADDR_B_W-1:0] adb,
    input  logic                wreb,
    input  logic                oceb,
    input  logic [DATA_B_W-1:0] dinb,
    output logic [DATA_B_W-1:0] doutb
);

    localparam int LANE_ROWS = DEPTH_BITS / LANES;

    bit_addr_t          a_addr;
    logic               a_wr;
    logic               a_rd;
    logic               b_wr;
    logic               b_rd;
    logic               same_row;
    logic [LANES-1:0]   lane_a_we;
    logic [LANES-1:0]   lane_b_we;
    logic [LANES-1:0]   lane_a_q;
    logic [LANES-1:0]   lane_b_q;
    logic [SEL_W-1:0]   sel_reg;

    assign a_addr   = ada;
    assign a_wr     = cea & wrea;
    assign a_rd     = cea & ocea;
    assign b_wr     = ceb & wreb;
    assign b_rd     = ceb & oceb;
    assign same_row = (a_addr.row == adb);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_a_we[gi] = a_wr & lane_hit(a_addr.sel, SEL_W'(gi));
            // Port A owns the bit when both ports write it on the same edge.
            assign lane_b_we[gi] = b_wr & ~(lane_a_we[gi] & same_row);

            eeprom_bit_lane #(
                .ROWS (LANE_ROWS)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .a_we  (lane_a_we[gi]),
                .a_re  (a_rd),
                .a_row (a_addr.row),
                .a_din (dina),
                .a_q   (lane_a_q[gi]),
                .b_we  (lane_b_we[gi]),
                .b_re  (b_rd),
                .b_row (adb),
                .b_din (dinb[gi]),
                .b_q   (lane_b_q[gi])
            );
        end
    endgenerate

    // Every lane is read on port A; the registered bit select picks the one addressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg <= '0;
        end else if (a_rd) begin
            sel_reg <= a_addr.sel;
        end
    end

    assign douta = lane_a_q[sel_reg];
    assign doutb = lane_b_q;

endmodule

// File: tb/tb_eeprom_dpram.sv
// Bench for eeprom_dpram: directed vector table, reset sequence and random traffic against a bit-array model.
module tb_eeprom_dpram;

    logic        clk;
    logic        rst_n;
    logic        cea;
    logic [15:0] ada;
    logic        wrea;
    logic        ocea;
    logic        dina;
    logic        douta;
    logic        ceb;
    logic [12:0] adb;
    logic        wreb;
    logic        oceb;
    logic [7:0]  dinb;
    logic [7:0]  doutb;

    typedef struct {
        logic        cea;
        logic [15:0] ada;
        logic        wrea;
        logic        ocea;
        logic        dina;
        logic        ceb;
        logic [12:0] adb;
        logic        wreb;
        logic        oceb;
        logic [7:0]  dinb;
        logic        exp_a;
        logic [7:0]  exp_b;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit       model_mem [65536];
    logic     exp_a;
    logic [7:0] exp_b;

    eeprom_dpram #(.DEPTH_BITS(65536)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cea   (cea),
        .ada   (ada),
        .wrea  (wrea),
        .ocea  (ocea),
        .dina  (dina),
        .douta (douta),
        .ceb   (ceb),
        .adb   (adb),
        .wreb  (wreb),
        .oceb  (oceb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic c_a, input logic [15:0] a_a, input logic w_a, input logic o_a,
                                 input logic d_a, input logic c_b, input logic [12:0] a_b, input logic w_b,
                                 input logic o_b, input logic [7:0] d_b, input logic e_a, input logic [7:0] e_b);
        vec_t v;
        v.cea = c_a; v.ada = a_a; v.wrea = w_a; v.ocea = o_a; v.dina = d_a;
        v.ceb = c_b; v.adb = a_b; v.wreb = w_b; v.oceb = o_b; v.dinb = d_b;
        v.exp_a = e_a; v.exp_b = e_b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drives one cycle from a negedge, advances the model, and compares at the next negedge.
    task automatic apply(input vec_t v, input bit use_tbl, input string tag);
        bit         ra;
        logic [7:0] rb;
        cea = v.cea; ada = v.ada; wrea = v.wrea; ocea = v.ocea; dina = v.dina;
        ceb = v.ceb; adb = v.adb; wreb = v.wreb; oceb = v.oceb; dinb = v.dinb;
        @(posedge clk);
        ra = model_mem[int'(v.ada)];
        for (int i = 0; i < 8; i++) rb[i] = model_mem[int'(v.adb) * 8 + i];
        if (v.cea && v.ocea) exp_a = ra;
        if (v.ceb && v.oceb) exp_b = rb;
        if (v.ceb && v.wreb)
            for (int i = 0; i < 8; i++) model_mem[int'(v.adb) * 8 + i] = v.dinb[i];
        if (v.cea && v.wrea) model_mem[int'(v.ada)] = v.dina;
        @(negedge clk);
        chk({tag, "_douta_model"}, {7'b0, douta}, {7'b0, exp_a});
        chk({tag, "_doutb_model"}, doutb, exp_b);
        if (use_tbl) begin
            chk({tag, "_douta_tbl"}, {7'b0, douta}, {7'b0, v.exp_a});
            chk({tag, "_doutb_tbl"}, doutb, v.exp_b);
        end
        $display("%s: ada=%h cea=%b wrea=%b adb=%h ceb=%b wreb=%b -> douta=%b doutb=%h",
                 tag, v.ada, v.cea, v.wrea, v.adb, v.ceb, v.wreb, douta, doutb);
    endtask

    vec_t tbl[$];
    vec_t v;
    logic [7:0] a5;

    initial begin
        rst_n = 1'b0;
        cea = 0; ada = '0; wrea = 0; ocea = 0; dina = 0;
        ceb = 0; adb = '0; wreb = 0; oceb = 0; dinb = '0;
        exp_a = 1'b0;
        exp_b = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_douta", {7'b0, douta}, 8'h00);
        chk("reset_doutb", doutb, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Clear storage with the read path held so outputs stay at their reset value.
        for (int r = 0; r < 8192; r++) begin
            cea = 0; ceb = 1; adb = 13'(r); wreb = 1; oceb = 0; dinb = 8'h00;
            @(posedge clk);
            for (int i = 0; i < 8; i++) model_mem[r * 8 + i] = 1'b0;
        end
        @(negedge clk);
        chk("clear_douta", {7'b0, douta}, 8'h00);
        chk("clear_doutb", doutb, 8'h00);

        a5 = 8'hA5;
        for (int k = 0; k < 8; k++)
            tbl.push_back(mkv(1, 16'(8 + k), 1, 0, 1, 0, 13'h0, 0, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h1, 0, 1, 8'h00, 0, 8'hFF));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h1FFF, 1, 1, 8'hA5, 0, 8'h00));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mkv(1, 16'(16'hFFF8 + k), 0, 1, 0, 0, 13'h0, 0, 0, 8'h00, a5[k], 8'h00));
        tbl.push_back(mkv(1, 16'h0100, 1, 1, 1, 0, 13'h0, 0, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mkv(1, 16'h0100, 0, 1, 0, 0, 13'h0, 0, 0, 8'h00, 1, 8'h00));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 0, 13'h5, 1, 1, 8'h3C, 1, 8'h00));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h5, 0, 1, 8'h00, 1, 8'h00));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h1, 0, 1, 8'h00, 1, 8'hFF));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h2, 1, 0, 8'h77, 1, 8'hFF));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h2, 0, 1, 8'h00, 1, 8'h77));
        tbl.push_back(mkv(1, 16'h0000, 1, 0, 0, 1, 13'h0, 1, 0, 8'hFF, 1, 8'h77));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h0, 0, 1, 8'h00, 1, 8'hFE));
        tbl.push_back(mkv(1, 16'h0018, 1, 0, 1, 1, 13'h3, 0, 1, 8'h00, 1, 8'h00));
        tbl.push_back(mkv(0, 16'h0, 0, 0, 0, 1, 13'h3, 0, 1, 8'h00, 1, 8'h01));

        for (int t = 0; t < tbl.size(); t++) apply(tbl[t], 1'b1, $sformatf("tbl%0d", t));

        // Asynchronous reset mid-cycle, with a write on the edge that occurs during reset.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_douta", {7'b0, douta}, 8'h00);
        chk("async_rst_doutb", doutb, 8'h00);
        cea = 0; ceb = 1; adb = 13'h9; wreb = 1; oceb = 1; dinb = 8'h5A;
        @(posedge clk);
        for (int i = 0; i < 8; i++) model_mem[9 * 8 + i] = dinb[i];
        exp_a = 1'b0;
        exp_b = 8'h00;
        @(negedge clk);
        chk("in_rst_douta", {7'b0, douta}, 8'h00);
        chk("in_rst_doutb", doutb, 8'h00);
        $display("reset: write adb=009 din=5a under reset -> douta=%b doutb=%h", douta, doutb);
        rst_n = 1'b1;
        apply(mkv(0, 16'h0, 0, 0, 0, 1, 13'h9, 0, 1, 8'h00, 0, 8'h5A), 1'b1, "rst_wr_kept");
        apply(mkv(0, 16'h0, 0, 0, 0, 1, 13'h1, 0, 1, 8'h00, 0, 8'hFF), 1'b1, "rst_survive");

        // Random traffic concentrated on a few rows so collisions and cross-port hazards occur.
        for (int t = 0; t < 3000; t++) begin
            logic [12:0] row_a;
            logic [12:0] row_b;
            row_a = ($urandom_range(0, 3) != 0) ? 13'($urandom_range(0, 7)) : 13'($urandom);
            row_b = ($urandom_range(0, 3) != 0) ? 13'($urandom_range(0, 7)) : 13'($urandom);
            v = mkv($urandom_range(0, 4) != 0, {row_a, 3'($urandom)}, 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 4) != 0, row_b, 1'($urandom), 1'($urandom),
                    8'($urandom), 0, 8'h00);
            apply(v, 1'b0, $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
